// File: rtl/exu_alu_issue.sv
// exu_alu_issue: issue/hold/capture controller in front of the combinational RV64 ALU.
// Decodes an integer op into alu_sel/alu_a/alu_b, holds them for a per-class latency,
// then captures alu_res and offers it to write-back over a valid/ready handshake.
module exu_alu_issue #(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic [63:0] imm,
    input  logic [63:0] pc,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [4:0]  alu_sel,
    input  logic [63:0] alu_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_res,
    output logic        out_illegal
);

    localparam int unsigned XLEN    = 64;
    localparam int unsigned SEL_W   = 5;
    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [SEL_W-1:0] SEL_ADD   = 5'd0;
    localparam logic [SEL_W-1:0] SEL_SUB   = 5'd1;
    localparam logic [SEL_W-1:0] SEL_MUL   = 5'd2;
    localparam logic [SEL_W-1:0] SEL_DIV   = 5'd3;
    localparam logic [SEL_W-1:0] SEL_DIVU  = 5'd4;
    localparam logic [SEL_W-1:0] SEL_REM   = 5'd5;
    localparam logic [SEL_W-1:0] SEL_REMU  = 5'd6;
    localparam logic [SEL_W-1:0] SEL_AND   = 5'd7;
    localparam logic [SEL_W-1:0] SEL_OR    = 5'd8;
    localparam logic [SEL_W-1:0] SEL_XOR   = 5'd9;
    localparam logic [SEL_W-1:0] SEL_LTU   = 5'd11;
    localparam logic [SEL_W-1:0] SEL_LT    = 5'd15;
    localparam logic [SEL_W-1:0] SEL_SLL   = 5'd16;
    localparam logic [SEL_W-1:0] SEL_SRL   = 5'd17;
    localparam logic [SEL_W-1:0] SEL_SRA   = 5'd18;
    localparam logic [SEL_W-1:0] SEL_ADDW  = 5'd19;
    localparam logic [SEL_W-1:0] SEL_SUBW  = 5'd20;
    localparam logic [SEL_W-1:0] SEL_SLLW  = 5'd21;
    localparam logic [SEL_W-1:0] SEL_SRLW  = 5'd22;
    localparam logic [SEL_W-1:0] SEL_SRAW  = 5'd23;
    localparam logic [SEL_W-1:0] SEL_MULW  = 5'd24;
    localparam logic [SEL_W-1:0] SEL_DIVW  = 5'd25;
    localparam logic [SEL_W-1:0] SEL_DIVUW = 5'd26;
    localparam logic [SEL_W-1:0] SEL_REMW  = 5'd27;
    localparam logic [SEL_W-1:0] SEL_REMUW = 5'd28;

    localparam logic [XLEN-1:0] SH64_MASK = XLEN'(63);
    localparam logic [XLEN-1:0] SH32_MASK = XLEN'(31);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   alu_a_q, alu_a_d;
    logic [XLEN-1:0]   alu_b_q, alu_b_d;
    logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
    logic [XLEN-1:0]   out_res_q, out_res_d;
    logic              out_illegal_q, out_illegal_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [XLEN-1:0]   dec_a;
    logic [XLEN-1:0]   dec_b;
    logic [XLEN-1:0]   dec_b_m;
    logic [SEL_W-1:0]  dec_sel;
    logic              dec_ill;
    logic [CNT_W-1:0]  dec_lat_m1;

    // Instruction decode: operand sources, ALU select and legality.
    always_comb begin
        dec_a   = src1;
        dec_b   = src2;
        dec_sel = SEL_ADD;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'd0:    dec_sel = SEL_ADD;
                            3'd1:    dec_sel = SEL_SLL;
                            3'd2:    dec_sel = SEL_LT;
                            3'd3:    dec_sel = SEL_LTU;
                            3'd4:    dec_sel = SEL_XOR;
                            3'd5:    dec_sel = SEL_SRL;
                            3'd6:    dec_sel = SEL_OR;
                            default: dec_sel = SEL_AND;
                        endcase
                    end
                    F7_ALT: begin
                        case (funct3)
                            3'd0:    dec_sel = SEL_SUB;
                            3'd5:    dec_sel = SEL_SRA;
                            default: dec_ill = 1'b1;
                        endcase
                    end
                    F7_MEXT: begin
                        case (funct3)
                            3'd0:    dec_sel = SEL_MUL;
                            3'd4:    dec_sel = SEL_DIV;
                            3'd5:    dec_sel = SEL_DIVU;
                            3'd6:    dec_sel = SEL_REM;
                            3'd7:    dec_sel = SEL_REMU;
                            default: dec_ill = 1'b1;
                        endcase
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_OP32: begin
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'd0:    dec_sel = SEL_ADDW;
                            3'd1:    dec_sel = SEL_SLLW;
                            3'd5:    dec_sel = SEL_SRLW;
                            default: dec_ill = 1'b1;
                        endcase
                    end
                    F7_ALT: begin
                        case (funct3)
                            3'd0:    dec_sel = SEL_SUBW;
                            3'd5:    dec_sel = SEL_SRAW;
                            default: dec_ill = 1'b1;
                        endcase
                    end
                    F7_MEXT: begin
                        case (funct3)
                            3'd0:    dec_sel = SEL_MULW;
                            3'd4:    dec_sel = SEL_DIVW;
                            3'd5:    dec_sel = SEL_DIVUW;
                            3'd6:    dec_sel = SEL_REMW;
                            3'd7:    dec_sel = SEL_REMUW;
                            default: dec_ill = 1'b1;
                        endcase
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                // funct7[0] carries shamt[5] for the 64-bit immediate shifts
                dec_b = imm;
                case (funct3)
                    3'd0: dec_sel = SEL_ADD;
                    3'd1: begin
                        if (funct7[6:1] == 6'b000000) dec_sel = SEL_SLL;
                        else                          dec_ill = 1'b1;
                    end
                    3'd2: dec_sel = SEL_LT;
                    3'd3: dec_sel = SEL_LTU;
                    3'd4: dec_sel = SEL_XOR;
                    3'd5: begin
                        if (funct7[6:1] == 6'b000000)      dec_sel = SEL_SRL;
                        else if (funct7[6:1] == 6'b010000) dec_sel = SEL_SRA;
                        else                               dec_ill = 1'b1;
                    end
                    3'd6:    dec_sel = SEL_OR;
                    default: dec_sel = SEL_AND;
                endcase
            end
            OPC_OPIMM32: begin
                dec_b = imm;
                case (funct3)
                    3'd0: dec_sel = SEL_ADDW;
                    3'd1: begin
                        if (funct7 == F7_BASE) dec_sel = SEL_SLLW;
                        else                   dec_ill = 1'b1;
                    end
                    3'd5: begin
                        if (funct7 == F7_BASE)     dec_sel = SEL_SRLW;
                        else if (funct7 == F7_ALT) dec_sel = SEL_SRAW;
                        else                       dec_ill = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_a = '0;
                dec_b = imm;
            end
            OPC_AUIPC: begin
                dec_a = pc;
                dec_b = imm;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Shift-amount masking and latency class of the decoded op.
    always_comb begin
        dec_b_m    = dec_b;
        dec_lat_m1 = '0;
        case (dec_sel)
            SEL_SLL, SEL_SRL, SEL_SRA:    dec_b_m = dec_b & SH64_MASK;
            SEL_SLLW, SEL_SRLW, SEL_SRAW: dec_b_m = dec_b & SH32_MASK;
            default:                      dec_b_m = dec_b;
        endcase
        case (dec_sel)
            SEL_MUL, SEL_MULW:
                dec_lat_m1 = CNT_W'(MUL_LAT - 1);
            SEL_DIV, SEL_DIVU, SEL_REM, SEL_REMU,
            SEL_DIVW, SEL_DIVUW, SEL_REMW, SEL_REMUW:
                dec_lat_m1 = CNT_W'(DIV_LAT - 1);
            default:
                dec_lat_m1 = '0;
        endcase
    end

    // Next-state and register-input logic for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_sel_d     = alu_sel_q;
        out_res_d     = out_res_q;
        out_illegal_d = out_illegal_q;
        cnt_d         = cnt_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // in_ready_q is low for the first cycle after reset release
                    if (in_valid && in_ready_q) begin
                        alu_a_d   = dec_a;
                        alu_b_d   = dec_b_m;
                        alu_sel_d = dec_sel;
                        cnt_d     = dec_lat_m1;
                        if (dec_ill) begin
                            out_res_d     = '0;
                            out_illegal_d = 1'b1;
                            state_d       = S_RESP;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        out_res_d     = alu_res;
                        out_illegal_d = 1'b0;
                        state_d       = S_RESP;
                    end
                end
                S_RESP: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_RESP);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_sel_q     <= '0;
            out_res_q     <= '0;
            out_illegal_q <= 1'b0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_sel_q     <= alu_sel_d;
            out_res_q     <= out_res_d;
            out_illegal_q <= out_illegal_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
            cnt_q         <= cnt_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;
    assign out_res     = out_res_q;
    assign out_illegal = out_illegal_q;
    assign out_valid   = out_valid_q;
    assign in_ready    = in_ready_q;

endmodule

// File: tb/tb_exu_alu_issue.sv
// tb_exu_alu_issue: directed and random checks of exu_alu_issue against a table-driven reference.
module tb_exu_alu_issue;

    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned DIV_LAT = 8;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] src1, src2, imm, pc;
    logic [63:0] alu_a, alu_b;
    logic [4:0]  alu_sel;
    logic [63:0] alu_res;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_res;
    logic        out_illegal;

    int          n_checks;
    int          n_errors;
    logic [63:0] alu_noise;
    int          sel_map [bit [16:0]];
    logic [63:0] obs_a1, obs_b1, obs_res;
    logic [4:0]  obs_sel1;

    exu_alu_issue #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .src1(src1), .src2(src2), .imm(imm), .pc(pc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Behavioural ALU sitting on the DUT's operand bus
    function automatic logic [63:0] alu_f(input logic [4:0] s, input logic [63:0] a, input logic [63:0] b);
        logic [31:0] aw, bw;
        logic [63:0] r;
        logic        ov64, ov32;
        aw = a[31:0];
        bw = b[31:0];
        ov64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
        ov32 = (aw == 32'h8000_0000) && (bw == '1);
        r = '0;
        case (s)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a * b;
            5'd3:  if (b == 0) r = '1; else if (ov64) r = a; else r = 64'($signed(a) / $signed(b));
            5'd4:  if (b == 0) r = '1; else r = a / b;
            5'd5:  if (b == 0) r = a; else if (ov64) r = '0; else r = 64'($signed(a) % $signed(b));
            5'd6:  if (b == 0) r = a; else r = a % b;
            5'd7:  r = a & b;
            5'd8:  r = a | b;
            5'd9:  r = a ^ b;
            5'd10: r = 64'(a >= b);
            5'd11: r = 64'(a < b);
            5'd12: r = 64'(a == b);
            5'd13: r = 64'(a != b);
            5'd14: r = 64'($signed(a) >= $signed(b));
            5'd15: r = 64'($signed(a) < $signed(b));
            5'd16: r = a << b[5:0];
            5'd17: r = a >> b[5:0];
            5'd18: r = 64'($signed(a) >>> b[5:0]);
            5'd19: r = sx32(aw + bw);
            5'd20: r = sx32(aw - bw);
            5'd21: r = sx32(aw << bw[4:0]);
            5'd22: r = sx32(aw >> bw[4:0]);
            5'd23: r = sx32(32'($signed(aw) >>> bw[4:0]));
            5'd24: r = sx32(aw * bw);
            5'd25: if (bw == 0) r = '1; else if (ov32) r = sx32(aw); else r = sx32(32'($signed(aw) / $signed(bw)));
            5'd26: if (bw == 0) r = '1; else r = sx32(aw / bw);
            5'd27: if (bw == 0) r = sx32(aw); else if (ov32) r = '0; else r = sx32(32'($signed(aw) % $signed(bw)));
            5'd28: if (bw == 0) r = sx32(aw); else r = sx32(aw % bw);
            default: r = '0;
        endcase
        return r;
    endfunction

    assign alu_res = alu_f(alu_sel, alu_a, alu_b) ^ alu_noise;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One row of the legal-op table: sel per funct3, -1 where the encoding is illegal
    function automatic void add_row(input logic [6:0] o, input logic [6:0] f7v, input int row [8]);
        for (int i = 0; i < 8; i++)
            if (row[i] >= 0) sel_map[{o, f7v, 3'(i)}] = row[i];
    endfunction

    task automatic ref_decode(input logic [6:0] o, input logic [2:0] f3v, input logic [6:0] f7v,
                              input logic [63:0] s1, input logic [63:0] s2, input logic [63:0] im,
                              input logic [63:0] p, output logic [4:0] sel, output logic [63:0] a,
                              output logic [63:0] b, output bit ill, output int lat);
        logic [6:0] f7e;
        logic [2:0] f3e;
        bit [16:0]  key;
        f7e = f7v;
        f3e = f3v;
        if (o == 7'h13) f7e = (f3v == 3'd1 || f3v == 3'd5) ? {f7v[6:1], 1'b0} : 7'h00;
        else if (o == 7'h1B && !(f3v == 3'd1 || f3v == 3'd5)) f7e = 7'h00;
        else if (o == 7'h37 || o == 7'h17) begin f7e = 7'h00; f3e = 3'd0; end
        key = {o, f7e, f3e};
        ill = !sel_map.exists(key);
        sel = ill ? 5'd0 : 5'(sel_map[key]);
        a = (o == 7'h37) ? 64'd0 : (o == 7'h17) ? p : s1;
        b = (o == 7'h33 || o == 7'h3B) ? s2 : im;
        if (sel inside {5'd16, 5'd17, 5'd18}) b = b & 64'h3F;
        else if (sel inside {[5'd21:5'd23]}) b = b & 64'h1F;
        if (sel inside {5'd2, 5'd24}) lat = int'(MUL_LAT);
        else if (sel inside {[5'd3:5'd6], [5'd25:5'd28]}) lat = int'(DIV_LAT);
        else lat = 1;
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3v, input logic [6:0] f7v,
                         input logic [63:0] s1, input logic [63:0] s2, input logic [63:0] im,
                         input logic [63:0] p);
        opcode = o; funct3 = f3v; funct7 = f7v;
        src1 = s1; src2 = s2; imm = im; pc = p;
    endtask

    task automatic scramble();
        drive(7'($urandom), 3'($urandom), 7'($urandom), {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one op from IDLE (at a negedge) and follow it through to the completed result handshake
    task automatic do_op(input logic [6:0] o, input logic [2:0] f3v, input logic [6:0] f7v,
                         input logic [63:0] s1, input logic [63:0] s2, input logic [63:0] im,
                         input logic [63:0] p, input int hold, input bit busy);
        logic [4:0]  e_sel;
        logic [63:0] e_a, e_b, e_res;
        bit          e_ill;
        int          lat;
        ref_decode(o, f3v, f7v, s1, s2, im, p, e_sel, e_a, e_b, e_ill, lat);
        e_res = e_ill ? 64'd0 : alu_f(e_sel, e_a, e_b);
        chk("idle_in_ready", in_ready, 1);
        drive(o, f3v, f7v, s1, s2, im, p);
        in_valid = 1'b1;
        step();
        obs_a1 = alu_a; obs_b1 = alu_b; obs_sel1 = alu_sel;
        if (!e_ill) begin
            for (int k = 1; k <= lat; k++) begin
                scramble();
                in_valid = busy;
                chk("exec_out_valid", out_valid, 0);
                chk("exec_in_ready", in_ready, 0);
                chk("exec_alu_sel", alu_sel, e_sel);
                chk("exec_alu_a", alu_a, e_a);
                chk("exec_alu_b", alu_b, e_b);
                step();
            end
        end
        in_valid = 1'b0;
        obs_res = out_res;
        chk("resp_out_valid", out_valid, 1);
        chk("resp_out_res", out_res, e_res);
        chk("resp_out_illegal", out_illegal, e_ill);
        for (int h = 0; h < hold; h++) begin
            alu_noise = {$urandom, $urandom};
            step();
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_res", out_res, e_res);
            chk("hold_out_illegal", out_illegal, e_ill);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        alu_noise = '0;
        chk("post_in_ready", in_ready, 1);
        chk("post_out_valid", out_valid, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_sel"}, alu_sel, 0);
        chk({tag, "_out_res"}, out_res, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_illegal"}, out_illegal, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0]  r_o, r_f7;
        logic [2:0]  r_f3;
        logic [11:0] r_i;
        logic [6:0]  opc_tab [6];

        n_checks = 0; n_errors = 0; alu_noise = '0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive('0, '0, '0, '0, '0, '0, '0);
        opc_tab = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h37, 7'h17};

        add_row(7'h33, 7'h00, '{0, 16, 15, 11, 9, 17, 8, 7});
        add_row(7'h33, 7'h20, '{1, -1, -1, -1, -1, 18, -1, -1});
        add_row(7'h33, 7'h01, '{2, -1, -1, -1, 3, 4, 5, 6});
        add_row(7'h3B, 7'h00, '{19, 21, -1, -1, -1, 22, -1, -1});
        add_row(7'h3B, 7'h20, '{20, -1, -1, -1, -1, 23, -1, -1});
        add_row(7'h3B, 7'h01, '{24, -1, -1, -1, 25, 26, 27, 28});
        add_row(7'h13, 7'h00, '{0, 16, 15, 11, 9, 17, 8, 7});
        add_row(7'h13, 7'h20, '{-1, -1, -1, -1, -1, 18, -1, -1});
        add_row(7'h1B, 7'h00, '{19, 21, -1, -1, -1, 22, -1, -1});
        add_row(7'h1B, 7'h20, '{-1, -1, -1, -1, -1, 23, -1, -1});
        add_row(7'h37, 7'h00, '{0, -1, -1, -1, -1, -1, -1, -1});
        add_row(7'h17, 7'h00, '{0, -1, -1, -1, -1, -1, -1, -1});

        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // add 5+7
        do_op(7'h33, 3'd0, 7'h00, 64'd5, 64'd7, 64'd99, 64'd0, 0, 1'b0);
        chk("add_sel", obs_sel1, 0);
        chk("add_res", obs_res, 12);
        // sraiw with shamt field 0x43
        do_op(7'h1B, 3'd5, 7'h20, 64'hFFFF_0000_8000_1234, 64'd0, 64'h43, 64'd0, 1, 1'b1);
        chk("sraiw_sel", obs_sel1, 23);
        chk("sraiw_b", obs_b1, 3);
        // slli with imm 0x7F
        do_op(7'h13, 3'd1, 7'h00, 64'h1, 64'd0, 64'h7F, 64'd0, 0, 1'b0);
        chk("slli_sel", obs_sel1, 16);
        chk("slli_b", obs_b1, 64'h3F);
        // div held by backpressure
        do_op(7'h33, 3'd4, 7'h01, 64'd1000, 64'd7, 64'd0, 64'd0, 5, 1'b1);
        chk("div_sel", obs_sel1, 3);
        chk("div_res", obs_res, 142);
        // auipc
        do_op(7'h17, 3'd0, 7'h00, 64'h1234, 64'h5678, 64'h1000, 64'h8000_0000, 0, 1'b0);
        chk("auipc_a", obs_a1, 64'h8000_0000);
        chk("auipc_sel", obs_sel1, 0);
        chk("auipc_res", obs_res, 64'h8000_1000);

        // flush during cycle 3 of a div
        chk("fl_in_ready0", in_ready, 1);
        drive(7'h33, 3'd4, 7'h01, 64'd50, 64'd5, 64'd0, 64'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("fl_out_valid1", out_valid, 0);
        step();
        chk("fl_out_valid2", out_valid, 0);
        step();
        chk("fl_out_valid3", out_valid, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_out_valid4", out_valid, 0);
        chk("fl_in_ready4", in_ready, 1);
        do_op(7'h33, 3'd0, 7'h00, 64'd20, 64'd22, 64'd0, 64'd0, 0, 1'b0);
        chk("fl_add_res", obs_res, 42);

        // in_valid together with flush in IDLE is not accepted
        drive(7'h33, 3'd4, 7'h00, 64'd3, 64'd9, 64'd0, 64'd0);
        in_valid = 1'b1;
        flush = 1'b1;
        step();
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flv_in_ready", in_ready, 1);
        chk("flv_alu_sel", alu_sel, 0);
        chk("flv_alu_a", alu_a, 20);
        step();
        chk("flv_out_valid", out_valid, 0);
        chk("flv_in_ready2", in_ready, 1);

        // mulh is illegal
        do_op(7'h33, 3'd1, 7'h01, 64'd3, 64'd4, 64'd0, 64'd0, 2, 1'b0);
        chk("mulh_res", obs_res, 0);

        // asynchronous reset in the middle of a div
        drive(7'h33, 3'd4, 7'h01, 64'd77, 64'd7, 64'd0, 64'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        do_op(7'h33, 3'd0, 7'h20, 64'd10, 64'd3, 64'd0, 64'd0, 0, 1'b0);
        chk("rel_sub_res", obs_res, 7);

        // random ops
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 9) r_o = 7'($urandom);
            else r_o = opc_tab[$urandom_range(0, 5)];
            r_f3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0: r_f7 = 7'h00;
                1: r_f7 = 7'h20;
                2: r_f7 = 7'h01;
                default: r_f7 = 7'($urandom);
            endcase
            if (r_o == 7'h13 && $urandom_range(0, 1) == 1) r_f7[0] = 1'b1;
            r_i = 12'($urandom);
            do_op(r_o, r_f3, r_f7, {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom},
                  {{52{r_i[11]}}, r_i}, {$urandom, $urandom},
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
